color_calib_multi: RTL and testbench

COLOR_CALIB_MULTI -- requirements
Module: color_calib_multi

---
 rtl/color_calib_multi.sv | 219 +++++++++++++++++++++
 tb/tb_color_calib_multi.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_calib_multi.sv
// Colour calibration engine: averages an aligned square window of RGB pixels and stores
// averaged RGB plus derived YUV into one of several result slots, selectable for readout.
// slot_sel/rd_slot carry one extra bit so out-of-range slot numbers can be presented.
module color_calib_multi #(
    parameter int PIX_W     = 8,
    parameter int WIN_LOG2  = 3,
    parameter int NUM_SLOTS = 4,
    parameter int POS_W     = 13
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           pix_valid,
    input  logic        [PIX_W-1:0]        raw_r,
    input  logic        [PIX_W-1:0]        raw_g,
    input  logic        [PIX_W-1:0]        raw_b,
    input  logic        [POS_W-1:0]        row,
    input  logic        [POS_W-1:0]        col,
    input  logic        [POS_W-1:0]        win_row,
    input  logic        [POS_W-1:0]        win_col,
    input  logic                           start,
    input  logic                           abort,
    input  logic        [$clog2(NUM_SLOTS):0] slot_sel,
    input  logic        [$clog2(NUM_SLOTS):0] rd_slot,
    input  logic                           rgb_yuv,
    output logic        [PIX_W-1:0]        y_out,
    output logic signed [PIX_W:0]          u_out,
    output logic signed [PIX_W:0]          v_out,
    output logic        [NUM_SLOTS-1:0]    slot_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W  = $clog2(NUM_SLOTS);
    localparam int SEL_W  = IDX_W + 1;
    localparam int ACC_W  = PIX_W + 2 * WIN_LOG2;
    localparam int CNT_W  = 2 * WIN_LOG2 + 1;
    localparam int YS_W   = PIX_W + 10;
    localparam int PROD_W = PIX_W + 11;

    localparam logic [SEL_W-1:0]  NSLOT   = SEL_W'(NUM_SLOTS);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'((1 << (2 * WIN_LOG2)) - 1);
    localparam logic [POS_W:0]    WIN_M1  = (POS_W + 1)'((1 << WIN_LOG2) - 1);
    localparam logic [YS_W-1:0]   K_YR    = YS_W'(77);
    localparam logic [YS_W-1:0]   K_YG    = YS_W'(150);
    localparam logic [YS_W-1:0]   K_YB    = YS_W'(37);
    localparam logic [YS_W-1:0]   Y_MAX   = YS_W'((1 << PIX_W) - 1);
    localparam logic signed [PROD_W-1:0] K_U = PROD_W'(126);
    localparam logic signed [PROD_W-1:0] K_V = PROD_W'(225);

    typedef enum logic [1:0] {IDLE, ACCUM, CALC_Y, CALC_UV} state_t;

    state_t state_q, state_d;

    logic [POS_W-1:0] winRow_q, winCol_q;
    logic [IDX_W-1:0] slot_q;
    logic [ACC_W-1:0] accR_q, accG_q, accB_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PIX_W-1:0] avgR_q, avgG_q, avgB_q, yVal_q;
    logic             done_q;

    logic [PIX_W-1:0]        slotR_q [NUM_SLOTS];
    logic [PIX_W-1:0]        slotG_q [NUM_SLOTS];
    logic [PIX_W-1:0]        slotB_q [NUM_SLOTS];
    logic [PIX_W-1:0]        slotY_q [NUM_SLOTS];
    logic signed [PIX_W:0]   slotU_q [NUM_SLOTS];
    logic signed [PIX_W:0]   slotV_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    slotValid_q;

    logic             latchReq, accept, inWin;
    logic [POS_W:0]   rowLo, rowHi, colLo, colHi;
    logic [PIX_W-1:0] avgRc, avgGc, avgBc, ySat;
    logic [YS_W-1:0]  ySum, yShift;
    logic signed [PIX_W:0]    diffB, diffR, uVal, vVal;
    logic signed [PROD_W-1:0] prodU, prodV;
    logic [IDX_W-1:0] rdIdx;

    // Window bounds are widened by one bit so a window near the top of the range never wraps.
    always_comb begin
        rowLo = {1'b0, winRow_q};
        colLo = {1'b0, winCol_q};
        rowHi = rowLo + WIN_M1;
        colHi = colLo + WIN_M1;
        inWin = ({1'b0, row} >= rowLo) && ({1'b0, row} <= rowHi) &&
                ({1'b0, col} >= colLo) && ({1'b0, col} <= colHi);
    end

    always_comb begin
        state_d  = state_q;
        latchReq = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort && (slot_sel < NSLOT)) begin
                    latchReq = 1'b1;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pix_valid && inWin) begin
                    accept = 1'b1;
                    if (cnt_q == LAST) state_d = CALC_Y;
                end
            end
            CALC_Y:  state_d = CALC_UV;
            CALC_UV: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Luma uses the freshly divided accumulators; chroma uses the registered, saturated luma.
    always_comb begin
        avgRc  = PIX_W'(accR_q >> (2 * WIN_LOG2));
        avgGc  = PIX_W'(accG_q >> (2 * WIN_LOG2));
        avgBc  = PIX_W'(accB_q >> (2 * WIN_LOG2));
        ySum   = K_YR * {{10{1'b0}}, avgRc} + K_YG * {{10{1'b0}}, avgGc} +
                 K_YB * {{10{1'b0}}, avgBc};
        yShift = ySum >> 8;
        ySat   = (yShift > Y_MAX) ? {PIX_W{1'b1}} : PIX_W'(yShift);
        diffB  = $signed({1'b0, avgB_q} - {1'b0, yVal_q});
        diffR  = $signed({1'b0, avgR_q} - {1'b0, yVal_q});
        prodU  = K_U * $signed({{10{diffB[PIX_W]}}, diffB});
        prodV  = K_V * $signed({{10{diffR[PIX_W]}}, diffR});
        uVal   = (PIX_W + 1)'(prodU >>> 8);
        vVal   = (PIX_W + 1)'(prodV >>> 8);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            winRow_q <= '0;
            winCol_q <= '0;
            slot_q   <= '0;
            accR_q   <= '0;
            accG_q   <= '0;
            accB_q   <= '0;
            cnt_q    <= '0;
            avgR_q   <= '0;
            avgG_q   <= '0;
            avgB_q   <= '0;
            yVal_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            if (latchReq) begin
                winRow_q <= win_row;
                winCol_q <= win_col;
                slot_q   <= slot_sel[IDX_W-1:0];
                accR_q   <= '0;
                accG_q   <= '0;
                accB_q   <= '0;
                cnt_q    <= '0;
            end else if (accept) begin
                accR_q <= accR_q + {{(2 * WIN_LOG2){1'b0}}, raw_r};
                accG_q <= accG_q + {{(2 * WIN_LOG2){1'b0}}, raw_g};
                accB_q <= accB_q + {{(2 * WIN_LOG2){1'b0}}, raw_b};
                cnt_q  <= cnt_q + 1'b1;
            end
            if (state_q == CALC_Y) begin
                avgR_q <= avgRc;
                avgG_q <= avgGc;
                avgB_q <= avgBc;
                yVal_q <= ySat;
            end
            done_q <= (state_q == CALC_UV);
        end
    end

    // Slot contents change only in CALC_UV, so the previous result stays readable until then.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slotR_q[i] <= '0;
                slotG_q[i] <= '0;
                slotB_q[i] <= '0;
                slotY_q[i] <= '0;
                slotU_q[i] <= '0;
                slotV_q[i] <= '0;
            end
            slotValid_q <= '0;
        end else if (state_q == CALC_UV) begin
            slotR_q[slot_q]     <= avgR_q;
            slotG_q[slot_q]     <= avgG_q;
            slotB_q[slot_q]     <= avgB_q;
            slotY_q[slot_q]     <= yVal_q;
            slotU_q[slot_q]     <= uVal;
            slotV_q[slot_q]     <= vVal;
            slotValid_q[slot_q] <= 1'b1;
        end
    end

    assign rdIdx = rd_slot[IDX_W-1:0];

    always_comb begin
        y_out = '0;
        u_out = '0;
        v_out = '0;
        if (rd_slot < NSLOT) begin
            if (rgb_yuv) begin
                y_out = slotR_q[rdIdx];
                u_out = {1'b0, slotG_q[rdIdx]};
                v_out = {1'b0, slotB_q[rdIdx]};
            end else begin
                y_out = slotY_q[rdIdx];
                u_out = slotU_q[rdIdx];
                v_out = slotV_q[rdIdx];
            end
        end
    end

    assign slot_valid = slotValid_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_color_calib_multi.sv
// Directed bench for color_calib_multi: hand-computed averages, YUV values, done timing,
// window edges, abort, ignored starts and reset during calculation.
module tb_color_calib_multi;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              pix_valid;
    logic [7:0]        raw_r, raw_g, raw_b;
    logic [12:0]       row, col, win_row, win_col;
    logic              start, abort;
    logic [2:0]        slot_sel, rd_slot;
    logic              rgb_yuv;
    logic [7:0]        y_out;
    logic signed [8:0] u_out, v_out;
    logic [3:0]        slot_valid;
    logic              busy, done;

    int vectors    = 0;
    int miscompares = 0;

    color_calib_multi dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid),
        .raw_r(raw_r), .raw_g(raw_g), .raw_b(raw_b),
        .row(row), .col(col), .win_row(win_row), .win_col(win_col),
        .start(start), .abort(abort), .slot_sel(slot_sel), .rd_slot(rd_slot),
        .rgb_yuv(rgb_yuv), .y_out(y_out), .u_out(u_out), .v_out(v_out),
        .slot_valid(slot_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_slot(input logic [2:0] s, input logic mode);
        rd_slot = s;
        rgb_yuv = mode;
        #1;
    endtask

    // One full calibration of an 8x8 window with constant pixels, checking done timing and
    // that the target slot keeps reading oldY until the write.
    task automatic run_calib(input logic [12:0] wr, input logic [12:0] wc, input logic [2:0] s,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [7:0] oldY, input bit pulseStart, input bit stray);
        int  n;
        bit  early;
        rd_slot = s;
        rgb_yuv = 1'b0;
        win_row = wr;
        win_col = wc;
        slot_sel = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_busy: got %b expected 1", busy);
        end
        early = 1'b0;
        if (stray) begin
            raw_r = 8'd255; raw_g = 8'd255; raw_b = 8'd255;
            pix_valid = 1'b1; row = wr - 13'd1; col = wc; tick();
            pix_valid = 1'b1; row = wr; col = wc + 13'd8; tick();
            pix_valid = 1'b0; row = wr; col = wc; tick();
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                pix_valid = 1'b1;
                row = 13'(wr + 13'(i));
                col = 13'(wc + 13'(j));
                raw_r = r; raw_g = g; raw_b = b;
                if (pulseStart && n == 10) begin
                    start = 1'b1; slot_sel = 3'd0; win_row = 13'd0; win_col = 13'd0;
                end else begin
                    start = 1'b0;
                end
                tick();
                n++;
                if (n < 64 && (busy !== 1'b1 || done !== 1'b0)) early = 1'b1;
            end
        end
        pix_valid = 1'b0;
        start = 1'b0;
        vectors++;
        if (early) begin
            miscompares++;
            $display("[TB] FAIL accum_early_end: got early=1 expected 0");
        end
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || y_out !== oldY) begin
            miscompares++;
            $display("[TB] FAIL calc_y_cycle: got busy=%b done=%b y=%0d expected 1 0 %0d",
                     busy, done, y_out, oldY);
        end
        if (pulseStart) begin
            start = 1'b1; slot_sel = 3'd0;
        end
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || y_out !== oldY) begin
            miscompares++;
            $display("[TB] FAIL calc_uv_cycle: got busy=%b done=%b y=%0d expected 1 0 %0d",
                     busy, done, y_out, oldY);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_pulse: got done=%b busy=%b expected 1 0", done, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pix_valid = 1'b0; start = 1'b0; abort = 1'b0;
        raw_r = '0; raw_g = '0; raw_b = '0;
        row = '0; col = '0; win_row = '0; win_col = '0;
        slot_sel = '0; rd_slot = '0; rgb_yuv = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || slot_valid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got busy=%b done=%b valid=%b expected 0 0 0000",
                     busy, done, slot_valid);
        end
        for (int m = 0; m < 2; m++) begin
            read_slot(3'd1, m[0]);
            vectors++;
            if (y_out !== 8'd0 || u_out !== 9'sd0 || v_out !== 9'sd0) begin
                miscompares++;
                $display("[TB] FAIL reset_data: got %0d/%0d/%0d expected 0/0/0", y_out, u_out, v_out);
            end
        end
    endtask

    task automatic test_basic();
        run_calib(13'd10, 13'd20, 3'd1, 8'd200, 8'd100, 8'd50, 8'd0, 1'b0, 1'b0);
        read_slot(3'd1, 1'b0);
        vectors++;
        if (y_out !== 8'd125 || u_out !== -9'sd37 || v_out !== 9'sd65) begin
            miscompares++;
            $display("[TB] FAIL basic_yuv: got %0d/%0d/%0d expected 125/-37/65", y_out, u_out, v_out);
        end
        read_slot(3'd1, 1'b1);
        vectors++;
        if (y_out !== 8'd200 || u_out !== 9'sd100 || v_out !== 9'sd50) begin
            miscompares++;
            $display("[TB] FAIL basic_rgb: got %0d/%0d/%0d expected 200/100/50", y_out, u_out, v_out);
        end
        vectors++;
        if (slot_valid !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL basic_valid: got %b expected 0010", slot_valid);
        end
    endtask

    task automatic test_saturate();
        run_calib(13'd0, 13'd0, 3'd2, 8'd255, 8'd255, 8'd255, 8'd0, 1'b0, 1'b0);
        read_slot(3'd2, 1'b0);
        vectors++;
        if (y_out !== 8'd255 || u_out !== 9'sd0 || v_out !== 9'sd0) begin
            miscompares++;
            $display("[TB] FAIL sat_yuv: got %0d/%0d/%0d expected 255/0/0", y_out, u_out, v_out);
        end
        vectors++;
        if (slot_valid !== 4'b0110) begin
            miscompares++;
            $display("[TB] FAIL sat_valid: got %b expected 0110", slot_valid);
        end
    endtask

    task automatic test_window();
        run_calib(13'd100, 13'd200, 3'd0, 8'd16, 8'd32, 8'd64, 8'd0, 1'b0, 1'b1);
        read_slot(3'd0, 1'b1);
        vectors++;
        if (y_out !== 8'd16 || u_out !== 9'sd32 || v_out !== 9'sd64) begin
            miscompares++;
            $display("[TB] FAIL window_rgb: got %0d/%0d/%0d expected 16/32/64", y_out, u_out, v_out);
        end
        read_slot(3'd0, 1'b0);
        vectors++;
        if (y_out !== 8'd32 || u_out !== 9'sd15 || v_out !== -9'sd15) begin
            miscompares++;
            $display("[TB] FAIL window_yuv: got %0d/%0d/%0d expected 32/15/-15", y_out, u_out, v_out);
        end
    endtask

    task automatic test_no_wrap();
        bit ended;
        win_row = 13'd8190; win_col = 13'd0; slot_sel = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        ended = 1'b0;
        raw_r = 8'd50; raw_g = 8'd50; raw_b = 8'd50;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                pix_valid = 1'b1;
                row = (i < 6) ? 13'(i) : 13'(8184 + i);
                col = 13'(j);
                tick();
                if (busy !== 1'b1 || done !== 1'b0) ended = 1'b1;
            end
        end
        pix_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) ended = 1'b1;
        end
        vectors++;
        if (ended) begin
            miscompares++;
            $display("[TB] FAIL no_wrap: got completion expected still accumulating");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        read_slot(3'd3, 1'b1);
        vectors++;
        if (busy !== 1'b0 || slot_valid !== 4'b0111 || y_out !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL no_wrap_abort: got busy=%b valid=%b r=%0d expected 0 0111 0",
                     busy, slot_valid, y_out);
        end
    endtask

    task automatic test_abort();
        bit sawDone;
        win_row = 13'd0; win_col = 13'd0; slot_sel = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        raw_r = 8'd10; raw_g = 8'd10; raw_b = 8'd10;
        for (int n = 0; n < 30; n++) begin
            pix_valid = 1'b1;
            row = 13'(n / 8);
            col = 13'(n % 8);
            tick();
        end
        pix_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got busy=%b expected 0", busy);
        end
        sawDone = (done === 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done !== 1'b0) sawDone = 1'b1;
        end
        vectors++;
        if (sawDone) begin
            miscompares++;
            $display("[TB] FAIL abort_done: got done=1 expected 0");
        end
        read_slot(3'd1, 1'b1);
        vectors++;
        if (y_out !== 8'd200 || u_out !== 9'sd100 || v_out !== 9'sd50 || slot_valid !== 4'b0111) begin
            miscompares++;
            $display("[TB] FAIL abort_keep: got %0d/%0d/%0d valid=%b expected 200/100/50 0111",
                     y_out, u_out, v_out, slot_valid);
        end
        run_calib(13'd0, 13'd0, 3'd1, 8'd40, 8'd60, 8'd80, 8'd125, 1'b0, 1'b0);
        read_slot(3'd1, 1'b0);
        vectors++;
        if (y_out !== 8'd58 || u_out !== 9'sd10 || v_out !== -9'sd16) begin
            miscompares++;
            $display("[TB] FAIL recal_yuv: got %0d/%0d/%0d expected 58/10/-16", y_out, u_out, v_out);
        end
        read_slot(3'd1, 1'b1);
        vectors++;
        if (y_out !== 8'd40 || u_out !== 9'sd60 || v_out !== 9'sd80) begin
            miscompares++;
            $display("[TB] FAIL recal_rgb: got %0d/%0d/%0d expected 40/60/80", y_out, u_out, v_out);
        end
    endtask

    task automatic test_ignored_start();
        run_calib(13'd0, 13'd0, 3'd2, 8'd100, 8'd150, 8'd200, 8'd255, 1'b1, 1'b0);
        read_slot(3'd2, 1'b0);
        vectors++;
        if (y_out !== 8'd146 || u_out !== 9'sd26 || v_out !== -9'sd41 || slot_valid !== 4'b0111) begin
            miscompares++;
            $display("[TB] FAIL ignore_yuv: got %0d/%0d/%0d valid=%b expected 146/26/-41 0111",
                     y_out, u_out, v_out, slot_valid);
        end
        slot_sel = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bad_slot_start: got busy=%b expected 0", busy);
        end
        read_slot(3'd5, 1'b0);
        vectors++;
        if (y_out !== 8'd0 || u_out !== 9'sd0 || v_out !== 9'sd0) begin
            miscompares++;
            $display("[TB] FAIL rd_out_of_range_yuv: got %0d/%0d/%0d expected 0/0/0", y_out, u_out, v_out);
        end
        read_slot(3'd4, 1'b1);
        vectors++;
        if (y_out !== 8'd0 || u_out !== 9'sd0 || v_out !== 9'sd0) begin
            miscompares++;
            $display("[TB] FAIL rd_out_of_range_rgb: got %0d/%0d/%0d expected 0/0/0", y_out, u_out, v_out);
        end
    endtask

    task automatic test_reset_in_calc();
        bit sawDone;
        win_row = 13'd0; win_col = 13'd0; slot_sel = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        raw_r = 8'd50; raw_g = 8'd50; raw_b = 8'd50;
        for (int n = 0; n < 64; n++) begin
            pix_valid = 1'b1;
            row = 13'(n / 8);
            col = 13'(n % 8);
            tick();
        end
        pix_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || slot_valid !== 4'b0000 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_calc: got busy=%b valid=%b done=%b expected 0 0000 0",
                     busy, slot_valid, done);
        end
        reset_n = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
        end
        vectors++;
        if (sawDone) begin
            miscompares++;
            $display("[TB] FAIL reset_calc_done: got activity after reset expected none");
        end
        read_slot(3'd3, 1'b1);
        vectors++;
        if (y_out !== 8'd0 || u_out !== 9'sd0 || v_out !== 9'sd0) begin
            miscompares++;
            $display("[TB] FAIL reset_calc_data: got %0d/%0d/%0d expected 0/0/0", y_out, u_out, v_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_window();
        test_no_wrap();
        test_abort();
        test_ignored_start();
        test_reset_in_calc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
